// File: rtl/sha256_core_arb.sv
// Round-robin arbiter sharing one sha256_core between NUM_REQ message-level requesters.
// Optional idle-grant watchdog enabled by defining SHA256_ARB_TIMEOUT_EN.
module sha256_core_arb #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int BLOCK_W        = 512,
  parameter int DIGEST_W       = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_arb_req,
  input  logic [NUM_REQ-1:0]           req_arb_init,
  input  logic [NUM_REQ-1:0]           req_arb_next,
  input  logic [NUM_REQ-1:0]           req_arb_mode,
  input  logic [NUM_REQ*BLOCK_W-1:0]   req_arb_block,
  output logic [NUM_REQ-1:0]           arb_req_grant,
  output logic [NUM_REQ-1:0]           arb_req_ready,
  output logic [NUM_REQ-1:0]           arb_req_digest_valid,
  output logic [DIGEST_W-1:0]          arb_req_digest,
  output logic                         arb_core_init,
  output logic                         arb_core_next,
  output logic                         arb_core_mode,
  output logic [BLOCK_W-1:0]           arb_core_block,
  input  logic                         core_arb_ready,
  input  logic [DIGEST_W-1:0]          core_arb_digest,
  input  logic                         core_arb_digest_valid,
  output logic                         arb_timeout
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  if (NUM_REQ < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("sha256_core_arb: NUM_REQ and TIMEOUT_CYCLES must both be >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANTED = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] eligible;
  logic               grant_any;
  logic               g_req, g_init, g_next, g_mode;
  logic               fwd_ok;
  logic [BLOCK_W-1:0] g_block;
  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] win_onehot;
  logic [PTR_W-1:0]   win_next_ptr;

`ifdef SHA256_ARB_TIMEOUT_EN
  logic [NUM_REQ-1:0] mask_q, mask_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;
  logic               timeout_q, timeout_d;

  assign mask        = mask_q;
  assign arb_timeout = timeout_q;
`else
  assign mask        = '0;
  assign arb_timeout = 1'b0;
`endif

  // Everything below keys off the registered one-hot grant, so reductions replace an index decode.
  always_comb begin
    g_block = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) g_block = req_arb_block[i*BLOCK_W +: BLOCK_W];
    end
  end

  assign grant_any = |grant_q;
  assign g_req     = |(grant_q & req_arb_req);
  assign g_init    = |(grant_q & req_arb_init);
  assign g_next    = |(grant_q & req_arb_next);
  assign g_mode    = |(grant_q & req_arb_mode);
  assign fwd_ok    = (state_q == ST_GRANTED) && g_req;

  assign arb_req_grant        = grant_q;
  assign arb_req_ready        = grant_q & {NUM_REQ{core_arb_ready}};
  assign arb_req_digest_valid = grant_q & {NUM_REQ{core_arb_digest_valid}};
  assign arb_req_digest       = grant_any ? core_arb_digest : '0;
  assign arb_core_init        = fwd_ok & g_init;
  assign arb_core_next        = fwd_ok & g_next;
  assign arb_core_mode        = g_mode;
  assign arb_core_block       = g_block;

  assign eligible = req_arb_req & ~mask;

  // Rotating search starting at rr_ptr; the first eligible requester wins.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && eligible[idx]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(idx);
      end
    end
  end

  assign win_onehot   = NUM_REQ'(1) << win_idx;
  assign win_next_ptr = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
`ifdef SHA256_ARB_TIMEOUT_EN
    mask_d    = mask_q & req_arb_req;
    wdog_d    = wdog_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef SHA256_ARB_TIMEOUT_EN
        wdog_d = '0;
`endif
        if (win_found && core_arb_ready) begin
          grant_d  = win_onehot;
          rr_ptr_d = win_next_ptr;
          state_d  = ST_GRANTED;
        end
      end
      ST_GRANTED: begin
        if (!g_req) begin
          if (core_arb_ready) begin
            grant_d = '0;
            state_d = ST_IDLE;
`ifdef SHA256_ARB_TIMEOUT_EN
            wdog_d  = '0;
`endif
          end else begin
            state_d = ST_DRAIN;
          end
        end
`ifdef SHA256_ARB_TIMEOUT_EN
        else if (g_init || g_next) begin
          wdog_d = '0;
        end else if (core_arb_ready) begin
          // Grantee is holding an idle core: revoke and lock it out until it drops req.
          if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            state_d   = ST_DRAIN;
            mask_d    = mask_d | grant_q;
            timeout_d = 1'b1;
          end else begin
            wdog_d = wdog_q + WD_W'(1);
          end
        end
`endif
      end
      ST_DRAIN: begin
        if (core_arb_ready) begin
          grant_d = '0;
          state_d = ST_IDLE;
`ifdef SHA256_ARB_TIMEOUT_EN
          wdog_d  = '0;
`endif
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef SHA256_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q    <= '0;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      mask_q    <= mask_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end
`endif

endmodule

// File: tb/tb_sha256_core_arb.sv
// Randomized and directed bench for sha256_core_arb against a transaction-level ownership model.
module tb_sha256_core_arb;

  localparam int NR  = 4;
  localparam int BW  = 512;
  localparam int DW  = 256;
  localparam int TMO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req, init, next, mode;
  logic [NR*BW-1:0] blk;
  logic            core_ready, core_dv;
  logic [DW-1:0]   core_digest;
  logic [NR-1:0]   grant, rdy, dv;
  logic [DW-1:0]   digest;
  logic            c_init, c_next, c_mode, tmo;
  logic [BW-1:0]   c_block;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: who owns the core (-1 = nobody), whether the owner is being drained.
  int         o;
  bit         drain;
  int         rr;
  logic [NR-1:0] mmask;
  int         wd;
  bit         mto;

  localparam logic [BW-1:0] ABC_BLK = {32'h61626380, 416'h0, 64'h18};
  localparam logic [DW-1:0] ABC_DIG =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  sha256_core_arb #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TMO), .BLOCK_W(BW), .DIGEST_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req_arb_req(req), .req_arb_init(init), .req_arb_next(next), .req_arb_mode(mode),
    .req_arb_block(blk),
    .arb_req_grant(grant), .arb_req_ready(rdy), .arb_req_digest_valid(dv),
    .arb_req_digest(digest),
    .arb_core_init(c_init), .arb_core_next(c_next), .arb_core_mode(c_mode),
    .arb_core_block(c_block),
    .core_arb_ready(core_ready), .core_arb_digest(core_digest),
    .core_arb_digest_valid(core_dv),
    .arb_timeout(tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    o = -1; drain = 0; rr = 0; mmask = '0; wd = 0; mto = 0;
  endtask

  task automatic model_step();
    logic [NR-1:0] elig;
    int tmo_idx;
    bit nt;
    if (rst) begin
      model_reset();
      return;
    end
    nt = 0;
    tmo_idx = -1;
    if (o < 0) begin
      elig = req & ~mmask;
      if (elig != 0 && core_ready) begin
        for (int k = 0; k < NR; k++) begin
          int i;
          i = (rr + k) % NR;
          if (elig[i]) begin
            o = i; rr = (i + 1) % NR; drain = 0; wd = 0;
            break;
          end
        end
      end
    end else if (drain) begin
      if (core_ready) begin o = -1; wd = 0; end
    end else if (!req[o]) begin
      if (core_ready) begin o = -1; wd = 0; end
      else drain = 1;
    end
`ifdef SHA256_ARB_TIMEOUT_EN
    else if (init[o] || next[o]) wd = 0;
    else if (core_ready) begin
      if (wd == TMO - 1) begin
        drain = 1; tmo_idx = o; nt = 1;
      end else begin
        wd++;
      end
    end
`endif
    mmask = mmask & req;
    if (tmo_idx >= 0) mmask[tmo_idx] = 1'b1;
    mto = nt;
  endtask

  task automatic compare();
    logic [NR-1:0] eg, er, ed;
    logic          ei, en, em;
    logic [BW-1:0] eb;
    logic [DW-1:0] edig;
    eg = '0; er = '0; ed = '0; ei = 0; en = 0; em = 0; eb = '0; edig = '0;
    if (o >= 0) begin
      eg[o] = 1'b1;
      er[o] = core_ready;
      ed[o] = core_dv;
      em    = mode[o];
      eb    = blk[o*BW +: BW];
      edig  = core_digest;
      ei    = !drain && req[o] && init[o];
      en    = !drain && req[o] && next[o];
    end
    chk("grant", grant, eg);
    chk("req_ready", rdy, er);
    chk("req_digest_valid", dv, ed);
    chk("req_digest", digest, edig);
    chk("core_init", c_init, ei);
    chk("core_next", c_next, en);
    chk("core_mode", c_mode, em);
    chk("core_block", c_block, eb);
    chk("timeout", tmo, mto);
  endtask

  // Called at a negedge with inputs already driven: check, cross one posedge, return at next negedge.
  task automatic tick();
    #1;
    compare();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  logic [NR-1:0] t2_exp [5];
  int busy;

  initial begin
    t2_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst = 1'b1; req = '0; init = '0; next = '0; mode = '0; blk = '0;
    core_ready = 1'b0; core_dv = 1'b0; core_digest = '0;
    model_reset();
    @(negedge clk);
    tick();
    tick();
    chk("reset_grant", grant, 4'b0000);
    chk("reset_timeout", tmo, 1'b0);

    // T1: lone requester 0 hashes "abc"
    rst = 1'b0; req = 4'b0001; core_ready = 1'b1;
    tick();
    chk("t1_grant", grant, 4'b0001);
    init = 4'b0001; mode = 4'b0001; blk[BW-1:0] = ABC_BLK;
    #1;
    chk("t1_core_init", c_init, 1'b1);
    chk("t1_core_block", c_block, ABC_BLK);
    tick();
    init = '0; core_ready = 1'b0;
    tick(); tick(); tick();
    core_digest = ABC_DIG; core_dv = 1'b1; core_ready = 1'b1;
    #1;
    chk("t1_digest", digest, ABC_DIG);
    chk("t1_digest_valid", dv, 4'b0001);
    chk("t1_ready_grantee_only", rdy, 4'b0001);
    tick();
    core_dv = 1'b0;

    // T4: non-grantee init is dropped
    init = 4'b0010;
    #1;
    chk("t4_init_blocked", c_init, 1'b0);
    tick();
    init = '0;

    // T2: round-robin order with all requesting
    do_reset();
    req = 4'b1111; core_ready = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("t2_order", grant, t2_exp[k]);
      req = 4'b1111 & ~t2_exp[k];
      tick();
      req = 4'b1111;
      tick();
    end

    // T3: release while core busy drains first
    do_reset();
    req = 4'b0100; core_ready = 1'b1;
    tick();
    chk("t3_grant", grant, 4'b0100);
    req = 4'b0000; core_ready = 1'b0;
    tick();
    chk("t3_drain_hold", grant, 4'b0100);
    tick();
    chk("t3_drain_hold2", grant, 4'b0100);
    req = 4'b0001; core_ready = 1'b1;
    tick();
    chk("t3_released", grant, 4'b0000);
    tick();
    chk("t3_next_winner", grant, 4'b0001);

    // T5: asynchronous reset mid-message
    init = 4'b0001;
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    chk("t5_async_grant", grant, 4'b0000);
    chk("t5_async_init", c_init, 1'b0);
    tick();
    rst = 1'b0; init = '0; req = 4'b1000; core_ready = 1'b1;
    tick();
    chk("t5_regrant", grant, 4'b1000);
    req = '0;
    tick();

`ifdef SHA256_ARB_TIMEOUT_EN
    // T6: idle grantee is revoked and locked out until it drops req
    do_reset();
    req = 4'b0001; core_ready = 1'b1;
    tick();
    for (int k = 0; k < TMO - 1; k++) tick();
    chk("t6_no_early_timeout", tmo, 1'b0);
    tick();
    chk("t6_timeout_pulse", tmo, 1'b1);
    tick();
    chk("t6_pulse_end", tmo, 1'b0);
    chk("t6_revoked", grant, 4'b0000);
    tick(); tick();
    chk("t6_locked_out", grant, 4'b0000);
    req = '0;
    tick();
    req = 4'b0001;
    tick();
    chk("t6_regranted", grant, 4'b0001);
`endif

    // Randomized traffic
    do_reset();
    busy = 0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
        init[i] = ($urandom_range(0, 3) == 0);
        next[i] = ($urandom_range(0, 3) == 0);
      end
      mode = 4'($urandom);
      for (int w = 0; w < NR*BW/32; w++) blk[w*32 +: 32] = $urandom;
      for (int w = 0; w < DW/32; w++) core_digest[w*32 +: 32] = $urandom;
      core_dv = ($urandom_range(0, 3) == 0);
      if (busy > 0) begin
        core_ready = 1'b0;
        busy--;
      end else begin
        core_ready = ($urandom_range(0, 5) != 0);
        if ($urandom_range(0, 15) == 0) busy = $urandom_range(1, 6);
      end
      if (!rst && $urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
